// File: rtl/adc_seq_pkg.sv
// ============================================================================
// adc_seq_pkg : shared state encoding and failure codes for the ADC sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package adc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLKRST  = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAL     = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5,
    S_FAIL    = 3'd6
  } seq_state_e;

  localparam logic [1:0] FAIL_NONE   = 2'd0;
  localparam logic [1:0] FAIL_CAL_TO = 2'd1;
  localparam logic [1:0] FAIL_SMP_TO = 2'd2;
  localparam logic [1:0] FAIL_ABORT  = 2'd3;

  function automatic logic is_active(input seq_state_e s);
    return (s == S_CLKRST) || (s == S_SETTLE) || (s == S_CAL) || (s == S_CAPTURE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_timer.sv
// ============================================================================
// seq_timer : loadable saturating down-counter shared by all timed phases
// Revision  : 1.0
// ============================================================================
`default_nettype none

module seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             core_clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge core_clock) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/adc_bringup_sequencer.sv
// ============================================================================
// adc_bringup_sequencer : ADC clock reset, settle, calibration and capture
// Revision              : 1.0
// ============================================================================
`default_nettype none

module adc_bringup_sequencer
  import adc_seq_pkg::*;
#(
  parameter int CLKRST_CYCLES  = 16,
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CAPTURE_LEN    = 256,
  parameter int CNT_W          = 16
) (
  input  logic             core_clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             clkrst_o,
  output logic             cal_req_o,
  input  logic             cal_ack_i,
  input  logic             sample_valid_i,
  output logic             sample_en_o,
  output logic [CNT_W-1:0] sample_count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [1:0]       fail_code_o
);

  // A phase of N cycles loads N-1: the exit edge is the one that sees zero.
  localparam logic [CNT_W-1:0] CLKRST_LOAD  = CNT_W'(CLKRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAPTURE_LAST = CNT_W'(CAPTURE_LEN);

  seq_state_e       state_q;
  logic             clkrst_q;
  logic             cal_req_q;
  logic             sample_en_q;
  logic             busy_q;
  logic             done_q;
  logic             fail_q;
  logic [1:0]       fail_code_q;
  logic [CNT_W-1:0] sample_count_q;
  logic [CNT_W-1:0] sample_count_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_en;
  logic             tmr_zero;

  assign sample_count_d = (sample_count_q == '1) ? sample_count_q
                                                 : sample_count_q + CNT_W'(1);

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_en    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          tmr_load  = 1'b1;
          tmr_value = CLKRST_LOAD;
        end
      end
      S_CLKRST: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = SETTLE_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_SETTLE: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = TIMEOUT_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_CAL: begin
        if (cal_ack_i) begin
          tmr_load  = 1'b1;
          tmr_value = TIMEOUT_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_CAPTURE: begin
        // Every accepted sample re-arms the inter-sample watchdog.
        if (sample_valid_i) begin
          tmr_load  = 1'b1;
          tmr_value = TIMEOUT_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .core_clock (core_clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .value_i    (tmr_value),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge core_clock) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      clkrst_q       <= 1'b0;
      cal_req_q      <= 1'b0;
      sample_en_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      fail_q         <= 1'b0;
      fail_code_q    <= FAIL_NONE;
      sample_count_q <= '0;
    end else if (abort_i && is_active(state_q)) begin
      state_q     <= S_FAIL;
      clkrst_q    <= 1'b0;
      cal_req_q   <= 1'b0;
      sample_en_q <= 1'b0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b1;
      fail_code_q <= FAIL_ABORT;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start_i) begin
            state_q        <= S_CLKRST;
            clkrst_q       <= 1'b1;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            fail_q         <= 1'b0;
            fail_code_q    <= FAIL_NONE;
            sample_count_q <= '0;
          end
        end
        S_CLKRST: begin
          if (tmr_zero) begin
            state_q  <= S_SETTLE;
            clkrst_q <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (tmr_zero) begin
            state_q   <= S_CAL;
            cal_req_q <= 1'b1;
          end
        end
        S_CAL: begin
          if (cal_ack_i) begin
            state_q     <= S_CAPTURE;
            cal_req_q   <= 1'b0;
            sample_en_q <= 1'b1;
          end else if (tmr_zero) begin
            state_q     <= S_FAIL;
            cal_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            fail_q      <= 1'b1;
            fail_code_q <= FAIL_CAL_TO;
          end
        end
        S_CAPTURE: begin
          if (sample_valid_i) begin
            sample_count_q <= sample_count_d;
            if (sample_count_d == CAPTURE_LAST) begin
              state_q     <= S_DONE;
              sample_en_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end else if (tmr_zero) begin
            state_q     <= S_FAIL;
            sample_en_q <= 1'b0;
            busy_q      <= 1'b0;
            fail_q      <= 1'b1;
            fail_code_q <= FAIL_SMP_TO;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          clkrst_q    <= 1'b0;
          cal_req_q   <= 1'b0;
          sample_en_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign clkrst_o       = clkrst_q;
  assign cal_req_o      = cal_req_q;
  assign sample_en_o    = sample_en_q;
  assign sample_count_o = sample_count_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign fail_o         = fail_q;
  assign fail_code_o    = fail_code_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_bringup_sequencer.sv
// ============================================================================
// tb_adc_bringup_sequencer : randomized scoreboard bench for the ADC sequencer
// Revision                 : 1.0
// ============================================================================
`default_nettype none

module tb_adc_bringup_sequencer;

  localparam int C = 4;
  localparam int S = 8;
  localparam int T = 32;
  localparam int L = 16;
  localparam int W = 16;

  logic         core_clock = 1'b0;
  logic         reset      = 1'b0;
  logic         start_i    = 1'b0;
  logic         abort_i    = 1'b0;
  logic         cal_ack_i  = 1'b0;
  logic         sample_valid_i = 1'b0;
  logic         clkrst_o;
  logic         cal_req_o;
  logic         sample_en_o;
  logic [W-1:0] sample_count_o;
  logic         busy_o;
  logic         done_o;
  logic         fail_o;
  logic [1:0]   fail_code_o;

  adc_bringup_sequencer #(
    .CLKRST_CYCLES  (C),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T),
    .CAPTURE_LEN    (L),
    .CNT_W          (W)
  ) dut (
    .core_clock     (core_clock),
    .reset          (reset),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .clkrst_o       (clkrst_o),
    .cal_req_o      (cal_req_o),
    .cal_ack_i      (cal_ack_i),
    .sample_valid_i (sample_valid_i),
    .sample_en_o    (sample_en_o),
    .sample_count_o (sample_count_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .fail_o         (fail_o),
    .fail_code_o    (fail_code_o)
  );

  always #5 core_clock = ~core_clock;

  int cyc = 0;
  always @(posedge core_clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected run outcome; times are edges relative to the start edge e0.
  typedef struct {
    int e0;
    int fall;
    int calr;
    int capr;
    int endt;
    int code;
    int count;
    bit is_done;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- monitor ----------------
  int   st_rise = -1, st_fall = -1, st_calr = -1, st_capr = -1;
  logic p_clkrst = 1'b0, p_calreq = 1'b0, p_sen = 1'b0, p_done = 1'b0, p_fail = 1'b0;
  exp_t mx;

  always @(negedge core_clock) begin
    if (clkrst_o === 1'b1 && p_clkrst !== 1'b1) begin
      st_rise = cyc; st_fall = -1; st_calr = -1; st_capr = -1;
    end
    if (clkrst_o === 1'b0 && p_clkrst === 1'b1) st_fall = cyc;
    if (cal_req_o === 1'b1 && p_calreq !== 1'b1) st_calr = cyc;
    if (sample_en_o === 1'b1 && p_sen !== 1'b1) st_capr = cyc;
    if ((done_o === 1'b1 && p_done !== 1'b1) || (fail_o === 1'b1 && p_fail !== 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_end_event", 1, 0);
      end else begin
        mx = exp_q.pop_front();
        check("end_time", cyc, mx.e0 + mx.endt);
        check("done_flag", done_o, mx.is_done);
        check("fail_flag", fail_o, !mx.is_done);
        check("fail_code", fail_code_o, mx.code);
        check("sample_count", sample_count_o, mx.count);
        check("clkrst_rise", st_rise, mx.e0);
        check("clkrst_fall", st_fall, mx.e0 + mx.fall);
        check("cal_req_rise", st_calr, (mx.calr < 0) ? -1 : mx.e0 + mx.calr);
        check("sample_en_rise", st_capr, (mx.capr < 0) ? -1 : mx.e0 + mx.capr);
        check("quiet_at_end", {clkrst_o, cal_req_o, sample_en_o, busy_o}, 0);
      end
    end
    p_clkrst = clkrst_o; p_calreq = cal_req_o; p_sen = sample_en_o;
    p_done = done_o; p_fail = fail_o;
  end

  // ---------------- stimulus plan and reference model ----------------
  int p_d, p_ra, p_xstart, p_spur, p_noise, p_post_smp, p_post_abort;
  int p_smp[$];
  bit smp_mark[2048];

  task automatic clear_plan();
    p_d = 0; p_ra = 0; p_xstart = 0; p_spur = 0; p_noise = 0;
    p_post_smp = 0; p_post_abort = 0;
    p_smp.delete();
    for (int i = 0; i < 2048; i++) smp_mark[i] = 1'b0;
  endtask

  // mode 0: gap 2; mode 1: random 1..4 with occasional gap of exactly T
  task automatic gen_samples(input int n, input int mode);
    int prev, gap;
    prev = C + S + p_d;
    for (int k = 0; k < n; k++) begin
      if (mode == 0) gap = 2;
      else if ($urandom_range(0, 7) == 0) gap = T;
      else gap = int'($urandom_range(1, 4));
      prev += gap;
      p_smp.push_back(prev);
      smp_mark[prev] = 1'b1;
    end
  endtask

  task automatic model(output exp_t x);
    int calr, capr, prev, cnt, endt, code, fall;
    bit dn, stop;
    int counted[$];
    calr = C + S; capr = -1; cnt = 0; dn = 1'b0; fall = C;
    if (p_d >= 1 && p_d <= T) begin
      capr = calr + p_d;
      prev = capr;
      stop = 1'b0;
      for (int i = 0; i < p_smp.size(); i++) begin
        if (!stop) begin
          if (p_smp[i] - prev > T) begin
            stop = 1'b1;
          end else begin
            cnt++;
            counted.push_back(p_smp[i]);
            prev = p_smp[i];
            if (cnt == L) begin dn = 1'b1; stop = 1'b1; end
          end
        end
      end
      if (dn) begin endt = prev; code = 0; end
      else begin endt = prev + T; code = 2; end
    end else begin
      endt = calr + T;
      code = 1;
    end
    if (p_ra >= 1 && p_ra <= endt) begin
      endt = p_ra; dn = 1'b0; code = 3; cnt = 0;
      foreach (counted[i]) if (counted[i] < p_ra) cnt++;
      if (p_ra <= C) fall = p_ra;
      if (p_ra <= calr) calr = -1;
      if (capr >= 0 && p_ra <= capr) capr = -1;
    end
    x.e0 = 0; x.fall = fall; x.calr = calr; x.capr = capr; x.endt = endt;
    x.code = code; x.count = cnt; x.is_done = dn;
  endtask

  task automatic drive_run(input int kind);
    exp_t x;
    int   rr;
    clear_plan();
    case (kind)
      0: begin p_d = 3; gen_samples(L, 0); end
      1, 4, 5: begin
        p_d = ($urandom_range(0, 3) == 0) ? T : int'($urandom_range(1, 6));
        gen_samples(L, 1);
      end
      2: p_d = ($urandom_range(0, 1) == 0) ? 0 : T + 1;
      3: begin p_d = 3; gen_samples(5, 0); end
      7: begin p_d = int'($urandom_range(1, 6)); gen_samples(int'($urandom_range(1, L - 1)), 1); end
      default: p_d = 0;
    endcase

    if (kind == 6) begin
      rr = C + int'($urandom_range(1, S));
      for (int r = 0; r <= rr; r++) begin
        start_i = (r == 0);
        reset   = (r == rr) ? 1'b0 : 1'b1;
        @(negedge core_clock);
        if (r == rr - 1) check("busy_before_reset", busy_o, 1);
      end
      check("reset_midrun_outputs",
            {clkrst_o, cal_req_o, sample_en_o, busy_o, done_o, fail_o, fail_code_o, sample_count_o}, 0);
      reset   = 1'b1;
      start_i = 1'b0;
    end else begin
      model(x);
      if (kind == 4) begin p_ra = p_smp[L - 1]; model(x); end
      if (kind == 5) begin p_ra = int'($urandom_range(1, x.endt)); model(x); end
      if (kind == 1 || kind == 2 || kind == 5 || kind == 7) begin
        p_spur   = int'($urandom_range(1, C + S));
        p_noise  = int'($urandom_range(1, (p_d >= 1 && p_d <= T) ? C + S + p_d : C + S + T));
        p_xstart = int'($urandom_range(1, x.endt));
        if ($urandom_range(0, 1) == 1) p_post_smp = x.endt + 1;
        if ($urandom_range(0, 1) == 1) p_post_abort = x.endt + 1;
      end
      x.e0 = cyc + 1;
      exp_q.push_back(x);
      for (int r = 0; r <= x.endt + 2; r++) begin
        start_i        = (r == 0) || (p_xstart != 0 && r == p_xstart);
        cal_ack_i      = (p_d > 0 && r == C + S + p_d) || (p_spur != 0 && r == p_spur);
        sample_valid_i = (r < 2048 && smp_mark[r]) || (p_noise != 0 && r == p_noise)
                         || (p_post_smp != 0 && r == p_post_smp);
        abort_i        = (p_ra != 0 && r == p_ra) || (p_post_abort != 0 && r == p_post_abort);
        @(negedge core_clock);
        if (r == 0) begin
          check("start_clkrst_busy", {clkrst_o, busy_o}, 2'b11);
          check("start_clears_status", {done_o, fail_o, fail_code_o, sample_count_o}, 0);
        end
        if (r == x.endt + 2) begin
          check("end_event_seen", exp_q.size(), 0);
          exp_q.delete();
          check("count_frozen", sample_count_o, x.count);
          check("status_held", {done_o, fail_o, fail_code_o},
                (int'(x.is_done) << 3) | (int'(!x.is_done) << 2) | x.code);
        end
      end
      start_i = 1'b0; cal_ack_i = 1'b0; sample_valid_i = 1'b0; abort_i = 1'b0;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int kinds[4];
    kinds[0] = 1; kinds[1] = 2; kinds[2] = 5; kinds[3] = 7;
    reset   = 1'b0;
    start_i = 1'b1;
    repeat (3) @(negedge core_clock);
    check("reset_outputs",
          {clkrst_o, cal_req_o, sample_en_o, busy_o, done_o, fail_o, fail_code_o, sample_count_o}, 0);
    start_i = 1'b0;
    reset   = 1'b1;
    abort_i = 1'b1; cal_ack_i = 1'b1; sample_valid_i = 1'b1;
    repeat (2) @(negedge core_clock);
    check("idle_ignores_inputs", {fail_o, busy_o, done_o, sample_count_o}, 0);
    abort_i = 1'b0; cal_ack_i = 1'b0; sample_valid_i = 1'b0;
    @(negedge core_clock);

    drive_run(0);
    drive_run(2);
    drive_run(3);
    drive_run(4);
    drive_run(6);
    drive_run(0);
    drive_run(0);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0) drive_run(6);
      else drive_run(kinds[$urandom_range(0, 3)]);
    end
    repeat (2) @(negedge core_clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_bringup_sequencer.md
# adc_bringup_sequencer

Synchronous controller that sequences ADC bring-up and one capture window on `core_clock`. On `start` it pulses the ADC clock-generator reset (`clkrst`) and waits a settle interval. It then runs a req/ack calibration handshake and enables sample capture for exactly `CAPTURE_LEN` valid samples. It reports `done`, or `fail` with a code, which the harness maps onto its success/failure signalling.

## Interface
Parameters:
- `CLKRST_CYCLES`, default 16: cycles `clkrst` is held high; must be ≥1.
- `SETTLE_CYCLES`, default 64: idle cycles after `clkrst` drops; must be ≥1.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit, in cycles, for calibration ack and for the gap between samples.
- `CAPTURE_LEN`, default 256: valid samples per capture window; must be ≥1.
- `CNT_W`, default 16: counter width; must hold the maximum of all the above.

Ports:
- `core_clock`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low.
- `start`  in  1  run request; sampled only in IDLE, DONE and FAIL.
- `abort`  in  1  forces FAIL from any active state.
- `clkrst`  out  1  ADC clock-generator reset.
- `cal_req`  out  1  calibration request.
- `cal_ack`  in  1  calibration complete.
- `sample_valid`  in  1  ADC sample strobe.
- `sample_en`  out  1  capture window open.
- `sample_count`  out  CNT_W  valid samples accepted in the current window.
- `busy`  out  1  high in CLKRST, SETTLE, CAL and CAPTURE.
- `done`  out  1  capture completed.
- `fail`  out  1  run failed.
- `fail_code`  out  2  failure cause: 0 none, 1 calibration timeout, 2 sample timeout, 3 abort.

## Operation
- States: IDLE, CLKRST, SETTLE, CAL, CAPTURE, DONE, FAIL.
- IDLE: on `start` go to CLKRST.
- CLKRST: `clkrst`=1; after `CLKRST_CYCLES` cycles go to SETTLE.
- SETTLE: wait `SETTLE_CYCLES` cycles, then go to CAL.
- CAL: `cal_req`=1 from the first cycle of CAL.
  - `cal_ack` high → CAPTURE on the next edge.
  - `TIMEOUT_CYCLES` cycles without `cal_ack` → FAIL, code 1.
  - `cal_ack` outside CAL is ignored.
- CAPTURE: `sample_en`=1.
  - Each cycle with `sample_valid`=1 increments `sample_count`.
  - The increment that brings the count to `CAPTURE_LEN` moves to DONE.
  - The gap counter resets on every valid sample. `TIMEOUT_CYCLES` consecutive cycles without a sample → FAIL, code 2.
- DONE and FAIL: hold status.
  - `start` clears `done`, `fail`, `fail_code` and `sample_count`, then enters CLKRST.
  - `abort` in DONE, FAIL or IDLE has no effect.
- `abort` high in CLKRST, SETTLE, CAL or CAPTURE → FAIL, code 3, on the next edge.
- Priority on simultaneous events: abort > completion (ack or final sample) > timeout.
- `start` in an active state is ignored. No queueing.
- Counters saturate and never wrap.
- `sample_count` freezes in DONE and FAIL, and is zeroed on re-start.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, all counters 0. All outputs 0: `clkrst`, `cal_req`, `sample_en`, `busy`, `done`, `fail`, `fail_code`, `sample_count`.
- Reset mid-run returns the block to IDLE in one edge. The next run needs a fresh `start`.
- All outputs are registered, or decoded from the registered state only. There is no combinational input-to-output path.
- `start` sampled at edge t → `clkrst`=1 and `busy`=1 from t+1. `clkrst` is high for exactly `CLKRST_CYCLES` cycles.
- `cal_req` rises exactly `CLKRST_CYCLES`+`SETTLE_CYCLES` cycles after `clkrst` rises.
- `cal_ack` sampled at edge t → `cal_req`=0 and `sample_en`=1 from t+1.
- Final valid sample at edge t → from t+1: `sample_en`=0, `done`=1, `busy`=0, `sample_count`=`CAPTURE_LEN`.
  - The window is exact: a sample presented in the cycle after completion is not counted.
- Timeout at the `TIMEOUT_CYCLES`th waiting edge → `fail`=1 from the next cycle.
- Abort at edge t → from t+1: `fail`=1, `fail_code`=3, and `clkrst`, `cal_req`, `sample_en` all 0.

## Structure
- Shared package `adc_seq_pkg` holds:
  - the state enum;
  - fail-code constants `FAIL_NONE`, `FAIL_CAL_TO`, `FAIL_SMP_TO`, `FAIL_ABORT`.
- Sub-module `seq_timer`: a loadable, saturating down-counter (`load`, `value`, `en`, `zero`). It is shared by the CLKRST, SETTLE and CAL phases, and by the CAPTURE gap watchdog.
- The FSM and `sample_count` live in the top module.

## Test plan
Bench parameters: `CLKRST_CYCLES`=4, `SETTLE_CYCLES`=8, `TIMEOUT_CYCLES`=32, `CAPTURE_LEN`=16.
- Nominal: `start` pulse; `cal_ack` 3 cycles after `cal_req` rises; `sample_valid` every other cycle → `clkrst` high for exactly 4 cycles; `cal_req` rises 12 cycles after `clkrst`; `done`=1 one cycle after the 16th sample; `sample_count`=16; `fail`=0.
- Calibration timeout: never ack → `fail`=1, `fail_code`=1 after 32 CAL cycles; `sample_en` never asserted.
- Sample watchdog: 5 samples, then silence → `fail_code`=2 after 32 idle cycles; `sample_count` holds 5.
- Abort in CAPTURE with `sample_valid` in the same cycle as the 16th sample → `fail_code`=3; `done` stays 0.
- Reset mid-SETTLE → all outputs 0 the next cycle. A new `start` gives the full nominal sequence again.
- Re-run: after DONE, `start` → `done`, `fail` and `sample_count` cleared the next cycle. A `start` while `busy` → no effect on timing.
